// File: rtl/hsv_mask_ctrl_if.sv
// rtl/hsv_mask_ctrl_if.sv - pixel stream and host write bus for hsv_mask_ctrl
interface hsv_mask_ctrl_if;
  logic [12:0] row;
  logic [12:0] col;
  logic        iPix_valid;
  logic        iColor;
  logic        iWr_valid;
  logic [1:0]  iWr_addr;
  logic [7:0]  iWr_data;
  logic        oWr_ready;

  modport master (
    output row, col, iPix_valid, iColor, iWr_valid, iWr_addr, iWr_data,
    input  oWr_ready
  );

  modport slave (
    input  row, col, iPix_valid, iColor, iWr_valid, iWr_addr, iWr_data,
    output oWr_ready
  );
endinterface

// File: rtl/hsv_mask_ctrl.sv
// rtl/hsv_mask_ctrl.sv - per-frame mask pixel counter with frame-synchronous threshold commit
// Optional V_min auto-calibration is built only when HSV_AUTOCAL_EN is defined.
module hsv_mask_ctrl #(
  parameter int LAST_ROW = 477,
  parameter int LAST_COL = 617,
  parameter int CNT_LO   = 2000,
  parameter int CNT_HI   = 20000,
  parameter int V_STEP   = 4,
  parameter int V_FLOOR  = 16
) (
  input  logic           iCLK,
  input  logic           iRST_N,
  hsv_mask_ctrl_if.slave bus,
  output logic [7:0]     oV_min,
  output logic [1:0]     oS_shift,
  output logic           oMask_en,
  output logic [18:0]    oLast_count,
  output logic           oFrame_done
);

  typedef enum logic [1:0] {WAIT_SOF, COUNT, EVAL, COMMIT} state_t;

  localparam logic [12:0] ROW_MAX = 13'(LAST_ROW);
  localparam logic [12:0] COL_MAX = 13'(LAST_COL);

  state_t      state, state_nxt;
  logic [18:0] cnt, cnt_nxt;
  logic        sof, eof, hit, wr;
  logic [7:0]  v_sh;
  logic [1:0]  s_sh;
  logic        m_sh;
  logic        v_pend, s_pend, m_pend;

  assign sof = bus.iPix_valid && (bus.row == 13'd0) && (bus.col == 13'd0);
  assign eof = bus.iPix_valid && (bus.row == ROW_MAX) && (bus.col == COL_MAX);
  assign hit = bus.iPix_valid && bus.iColor && (bus.row <= ROW_MAX) && (bus.col <= COL_MAX);

  assign bus.oWr_ready = (state != COMMIT);
  assign oFrame_done   = (state == COMMIT);
  assign wr            = bus.iWr_valid && bus.oWr_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT_SOF: begin
        if (sof) begin
          state_nxt = COUNT;
          cnt_nxt   = {18'd0, bus.iColor};
        end
      end
      COUNT: begin
        // A new SOF here means the previous frame was truncated: restart silently.
        if (sof) begin
          cnt_nxt = {18'd0, bus.iColor};
        end else begin
          if (hit) cnt_nxt = cnt + 19'd1;
          if (eof) state_nxt = EVAL;
        end
      end
      EVAL:    state_nxt = COMMIT;
      COMMIT:  state_nxt = WAIT_SOF;
      default: state_nxt = WAIT_SOF;
    endcase
  end

`ifdef HSV_AUTOCAL_EN
  logic       cal_en, c_sh, c_pend;
  logic [7:0] cal_vmin, cand;
  logic [8:0] v_up;

  assign v_up = {1'b0, oV_min} + 9'(V_STEP);

  always_comb begin
    cand = oV_min;
    if (cnt > 19'(CNT_HI)) begin
      cand = v_up[8] ? 8'hFF : v_up[7:0];
    end else if (cnt < 19'(CNT_LO)) begin
      cand = ({1'b0, oV_min} < 9'(V_FLOOR + V_STEP)) ? 8'(V_FLOOR) : (oV_min - 8'(V_STEP));
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      cal_en   <= 1'b0;
      c_sh     <= 1'b0;
      c_pend   <= 1'b0;
      cal_vmin <= 8'd65;
    end else begin
      // Without calibration the candidate is simply the current threshold.
      if (state == EVAL) cal_vmin <= cal_en ? cand : oV_min;
      if (state == COMMIT) begin
        if (c_pend) cal_en <= c_sh;
        c_pend <= 1'b0;
      end else if (wr && (bus.iWr_addr == 2'd3)) begin
        c_sh   <= bus.iWr_data[0];
        c_pend <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state       <= WAIT_SOF;
      cnt         <= 19'd0;
      oLast_count <= 19'd0;
      oV_min      <= 8'd65;
      oS_shift    <= 2'd2;
      oMask_en    <= 1'b1;
      v_sh        <= 8'd65;
      s_sh        <= 2'd2;
      m_sh        <= 1'b1;
      v_pend      <= 1'b0;
      s_pend      <= 1'b0;
      m_pend      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == EVAL) oLast_count <= cnt;
      if (state == COMMIT) begin
`ifdef HSV_AUTOCAL_EN
        oV_min <= v_pend ? v_sh : cal_vmin;
`else
        if (v_pend) oV_min <= v_sh;
`endif
        if (s_pend) oS_shift <= s_sh;
        if (m_pend) oMask_en <= m_sh;
        v_pend <= 1'b0;
        s_pend <= 1'b0;
        m_pend <= 1'b0;
      end else if (wr) begin
        case (bus.iWr_addr)
          2'd0: begin
            v_sh   <= bus.iWr_data;
            v_pend <= 1'b1;
          end
          2'd1: begin
            s_sh   <= bus.iWr_data[1:0];
            s_pend <= 1'b1;
          end
          2'd2: begin
            m_sh   <= bus.iWr_data[0];
            m_pend <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hsv_mask_ctrl.sv
// tb/tb_hsv_mask_ctrl.sv - directed scoreboard bench for hsv_mask_ctrl on a reduced 16x16 frame
module tb_hsv_mask_ctrl;

  localparam int LR      = 15;
  localparam int LC      = 15;
  localparam int NPIX    = (LR + 1) * (LC + 1);
  localparam int C_LO    = 50;
  localparam int C_HI    = 200;
  localparam int STEP    = 4;
  localparam int FLOOR   = 16;
  localparam int OOB_AT  = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  v_min;
  logic [1:0]  s_shift;
  logic        mask_en;
  logic [18:0] last_count;
  logic        frame_done;

  hsv_mask_ctrl_if bus ();

  hsv_mask_ctrl #(
    .LAST_ROW(LR), .LAST_COL(LC), .CNT_LO(C_LO), .CNT_HI(C_HI),
    .V_STEP(STEP), .V_FLOOR(FLOOR)
  ) dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
    .bus         (bus),
    .oV_min      (v_min),
    .oS_shift    (s_shift),
    .oMask_en    (mask_en),
    .oLast_count (last_count),
    .oFrame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int eof_cyc = 0;
  int exp_q[$];

  int m_vmin, m_shift, m_mask, m_cal;
  int h_v, h_s, h_m, h_c;
  bit p_v, p_s, p_m, p_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic model_reset();
    m_vmin = 65; m_shift = 2; m_mask = 1; m_cal = 0;
    p_v = 0; p_s = 0; p_m = 0; p_c = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    chk("wr_ready", {31'd0, bus.oWr_ready}, 32'd1);
    bus.iWr_valid = 1'b1;
    bus.iWr_addr  = a;
    bus.iWr_data  = d;
    cyc();
    bus.iWr_valid = 1'b0;
    case (a)
      2'd0: begin h_v = d; p_v = 1; end
      2'd1: begin h_s = d[1:0]; p_s = 1; end
      2'd2: begin h_m = d[0]; p_m = 1; end
      default: begin
`ifdef HSV_AUTOCAL_EN
        h_c = d[0]; p_c = 1;
`endif
      end
    endcase
  endtask

  task automatic pix(input int r, input int c, input logic color);
    bus.iPix_valid = 1'b1;
    bus.row   = 13'(r);
    bus.col   = 13'(c);
    bus.iColor = color;
    cyc();
    chk("vmin_stable", {24'd0, v_min}, 32'(m_vmin));
    chk("no_done", {31'd0, frame_done}, 32'd0);
  endtask

  task automatic drive_range(input int first, input int last, input int mask_n,
                             input int wr_at, input logic [1:0] wa, input logic [7:0] wd);
    for (int idx = first; idx <= last; idx++) begin
      if (idx == wr_at) begin
        bus.iPix_valid = 1'b0;
        wr(wa, wd);
      end
      if (idx == OOB_AT) begin
        pix(LR + 1, idx % (LC + 1), 1'b1);
        pix(idx / (LC + 1), LC + 1, 1'b1);
      end
      pix(idx / (LC + 1), idx % (LC + 1), idx < mask_n);
    end
    bus.iPix_valid = 1'b0;
  endtask

  task automatic wait_done();
    int exp_cnt, cand;
    while (frame_done !== 1'b1 && cyc_cnt < eof_cyc + 8) cyc();
    chk("done_latency", 32'(cyc_cnt - eof_cyc), 32'd1);
    chk("done_pulse", {31'd0, frame_done}, 32'd1);
    chk("wr_ready_commit", {31'd0, bus.oWr_ready}, 32'd0);
    chk("vmin_hold_commit", {24'd0, v_min}, 32'(m_vmin));
    exp_cnt = exp_q.pop_front();
    chk("last_count", {13'd0, last_count}, 32'(exp_cnt));
    cand = m_vmin;
    if (m_cal != 0) begin
      if (exp_cnt > C_HI) cand = (m_vmin + STEP > 255) ? 255 : m_vmin + STEP;
      else if (exp_cnt < C_LO) cand = (m_vmin - STEP < FLOOR) ? FLOOR : m_vmin - STEP;
    end
    m_vmin = p_v ? h_v : cand;
    if (p_s) m_shift = h_s;
    if (p_m) m_mask = h_m;
    if (p_c) m_cal = h_c;
    p_v = 0; p_s = 0; p_m = 0; p_c = 0;
    cyc();
    chk("done_one_cycle", {31'd0, frame_done}, 32'd0);
    chk("vmin_after", {24'd0, v_min}, 32'(m_vmin));
    chk("shift_after", {30'd0, s_shift}, 32'(m_shift));
    chk("mask_after", {31'd0, mask_en}, 32'(m_mask));
  endtask

  task automatic frame(input int mask_n, input int wr_at = -1, input logic [1:0] wa = 2'd0,
                       input logic [7:0] wd = 8'd0, input bit ev = 1'b0,
                       input logic [1:0] ea = 2'd0, input logic [7:0] ed = 8'd0);
    int n;
    n = (mask_n > NPIX) ? NPIX : mask_n;
    drive_range(0, NPIX - 1, mask_n, wr_at, wa, wd);
    eof_cyc = cyc_cnt;
    exp_q.push_back(n);
    if (ev) wr(ea, ed);
    wait_done();
  endtask

  task automatic check_reset_state();
    chk("rst_vmin", {24'd0, v_min}, 32'd65);
    chk("rst_shift", {30'd0, s_shift}, 32'd2);
    chk("rst_mask", {31'd0, mask_en}, 32'd1);
    chk("rst_last", {13'd0, last_count}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_ready", {31'd0, bus.oWr_ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.row = '0; bus.col = '0; bus.iPix_valid = 1'b0; bus.iColor = 1'b0;
    bus.iWr_valid = 1'b0; bus.iWr_addr = '0; bus.iWr_data = '0;
    h_v = 0; h_s = 0; h_m = 0; h_c = 0;
    model_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    check_reset_state();

    frame(100);
    frame(30, 60, 2'd0, 8'h50);
    frame(10, -1, 2'd0, 8'd0, 1'b1, 2'd1, 8'd1);

    wr(2'd2, 8'd0);
    wr(2'd2, 8'd1);
    wr(2'd0, 8'h30);
    wr(2'd0, 8'h12);
    wr(2'd1, 8'd3);
    frame(120);
    wr(2'd2, 8'd0);
    frame(0);

    wr(2'd3, 8'd1);
    wr(2'd0, 8'h41);
    frame(100);
    frame(NPIX);
    wr(2'd0, 8'd18);
    frame(100);
    frame(10);
    frame(10);
    wr(2'd0, 8'h40);
    frame(NPIX);
    wr(2'd0, 8'hFD);
    frame(100);
    frame(NPIX);
    frame(NPIX);
    wr(2'd3, 8'd0);
    frame(NPIX);

    drive_range(0, 39, NPIX, -1, 2'd0, 8'd0);
    frame(77);

    wr(2'd1, 8'd0);
    drive_range(0, 49, NPIX, -1, 2'd0, 8'd0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    model_reset();
    check_reset_state();
    drive_range(50, NPIX - 1, NPIX, -1, 2'd0, 8'd0);
    repeat (4) cyc();
    chk("abandoned_last", {13'd0, last_count}, 32'd0);
    chk("abandoned_done", {31'd0, frame_done}, 32'd0);
    frame(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hsv_mask_ctrl.md
HSV_MASK_CTRL -- requirements
Module: hsv_mask_ctrl

Interface
REQ-001 SHALL have parameter LAST_ROW, default 477, meaning last active row.
REQ-002 SHALL have parameter LAST_COL, default 617, meaning last active column.
REQ-003 SHALL have parameter CNT_LO, default 2000, meaning the calibration low mask-pixel target.
REQ-004 SHALL have parameter CNT_HI, default 20000, meaning the calibration high mask-pixel target.
REQ-005 SHALL have parameter V_STEP, default 4, meaning the V_min calibration step.
REQ-006 SHALL have parameter V_FLOOR, default 16, meaning the lowest calibrated V_min.
REQ-007 SHALL have port iCLK  in  1  pixel clock.
REQ-008 SHALL have port iRST_N  in  1  one clock; reset is synchronous and active-low.
REQ-009 SHALL have ports row  in  13 and col  in  13, carrying the current pixel coordinate.
REQ-010 SHALL have port iPix_valid  in  1, meaning row/col/iColor are valid this cycle.
REQ-011 SHALL have port iColor  in  1, carrying the mask bit from the colour datapath.
REQ-012 SHALL have host write ports iWr_valid  in  1, iWr_addr  in  2, iWr_data  in  8 and oWr_ready  out  1.
REQ-013 SHALL have output oV_min  out  8, the V threshold driven to the datapath.
REQ-014 SHALL have output oS_shift  out  2, the S threshold shift (S > V>>shift).
REQ-015 SHALL have output oMask_en  out  1, the mask output enable.
REQ-016 SHALL have output oLast_count  out  19, the mask pixel count of the last complete frame.
REQ-017 SHALL have output oFrame_done  out  1, a one-cycle pulse at commit.

Function
REQ-018 SHALL implement FSM states WAIT_SOF, COUNT, EVAL and COMMIT.
REQ-019 SHALL define SOF as iPix_valid with row==0 and col==0, and EOF as iPix_valid with row==LAST_ROW and col==LAST_COL.
REQ-020 SHALL transition WAIT_SOF->COUNT on SOF, clearing the counter and counting the SOF pixel.
REQ-021 SHALL, in COUNT, increment the 19-bit counter on each iPix_valid&&iColor with row<=LAST_ROW and col<=LAST_COL; pixels outside that range are ignored.
REQ-022 SHALL, on EOF in COUNT, count the EOF pixel and go to EVAL at N+1, COMMIT at N+2 and WAIT_SOF at N+3.
REQ-023 SHALL, on SOF during COUNT (truncated frame), reset the counter to the SOF pixel value, remain in COUNT and skip EVAL.
REQ-024 SHALL, in EVAL, latch the counter into oLast_count and compute the candidate V_min.
REQ-025 SHALL, in COMMIT, assert oFrame_done and load all pending shadow fields; updated outputs SHALL be visible from N+3.
REQ-026 SHALL accept a write when iWr_valid&&oWr_ready, with oWr_ready=0 only in COMMIT.
REQ-027 SHALL map write addresses as 0=V_min, 1=S_shift (data[1:0]), 2=mask_en (data[0]), 3=cal_en (data[0]), each setting that field's pending flag.
REQ-028 SHALL let a later write to the same field before commit overwrite the shadow value.
REQ-029 SHALL commit a write accepted in the EOF or EVAL cycle in the immediately following COMMIT.
REQ-030 SHALL, when a host V_min is pending at COMMIT, load the host value and discard the calibration result.
REQ-031 SHALL never change outputs outside COMMIT, so thresholds remain stable for a whole frame.

Reset
REQ-032 SHALL, with iRST_N=0 at a clock edge, set state=WAIT_SOF, oV_min=65, oS_shift=2, oMask_en=1, cal_en=0, counter=0, oLast_count=0, oFrame_done=0, oWr_ready=1, and clear all pending flags.
REQ-033 SHALL, on reset mid-frame, abandon the frame without EVAL or COMMIT, and the next SOF SHALL start a fresh count.

Configuration
REQ-034 SHALL, with HSV_AUTOCAL_EN defined, when cal_en=1 compute in EVAL: count>CNT_HI -> V_min=min(255,V_min+V_STEP); count<CNT_LO -> V_min=max(V_FLOOR,V_min-V_STEP); otherwise unchanged.
REQ-035 SHALL, without HSV_AUTOCAL_EN, omit calibration logic, ignore writes to address 3, hold cal_en at 0, and change V_min only by host write.

Verification
REQ-036 SHALL verify: reset, then full frame with 100 mask pixels -> oLast_count=100, oFrame_done pulse at EOF+2, oV_min=65.
REQ-037 SHALL verify: write addr0=0x50 mid-frame -> oV_min stays 65 until EOF+3, then 0x50.
REQ-038 SHALL verify (HSV_AUTOCAL_EN, cal_en=1): frame count 30000 -> oV_min 65->69; count 500 with V_min=18 -> 16.
REQ-039 SHALL verify: host V_min=0x40 pending and count 30000 with cal_en=1 -> oV_min=0x40.
REQ-040 SHALL verify: SOF injected mid-COUNT -> no oFrame_done pulse; next full frame reports only its own count.
REQ-041 SHALL verify: iRST_N low mid-frame -> outputs at reset values, and a pixel at row 478 or col 618 is never counted.
